axi_cache_bridge: RTL and testbench
===================================

# axi_cache_bridge

- Sits between the Uranus cache layer and the AXI master ports that `mycpu_top` exposes.
- Converts line-refill and uncached single-word requests from the instruction cache (read only) and the data cache (read and write) into AXI3 bursts.
- Independent read and write channel FSMs; one outstanding read and one outstanding write at a time.

## Interface

- `LINE_WORDS`, 8, words per cache line; burst length = `LINE_WORDS`-1.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `ic_rd_req`, `ic_rd_burst`, `ic_rd_addr`  in  1/1/32  icache read request; burst=1 for line refill, 0 for single word.
- `ic_rd_gnt`  out  1  one-cycle pulse: request accepted.
- `ic_rd_valid`, `ic_rd_last`, `ic_rd_data`  out  1/1/32  returned beats.
- `dc_rd_req`, `dc_rd_burst`, `dc_rd_size`, `dc_rd_addr`  in  1/1/3/32  dcache read request.
- `dc_rd_gnt`, `dc_rd_valid`, `dc_rd_last`, `dc_rd_data`  out  1/1/1/32  dcache read grant and returned beats.
- `dc_wr_req`, `dc_wr_burst`, `dc_wr_size`, `dc_wr_addr`  in  1/1/3/32  dcache writeback or uncached store.
- `dc_wr_gnt`  out  1  write grant pulse.
- `dc_wd_valid`, `dc_wd_data`, `dc_wd_strb`  in  1/32/4  write data beat.
- `dc_wd_ready`  out  1  write data beat accepted.
- `dc_wr_done`  out  1  one-cycle pulse on B response.
- Full AXI3 master set (`ar*`, `r*`, `aw*`, `w*`, `b*`), same names and widths as the `mycpu_top` ports.

## Operation

- Constant AXI fields:
  - `arburst`/`awburst` = 2'b01 (INCR).
  - `arlock`, `awlock`, `arcache`, `awcache`, `arprot`, `awprot` = 0.
  - `awid` = `wid` = 1.
- `arid`: 0 for icache, 1 for dcache.
- `arsize`/`awsize`: 3'd2 for icache and for any burst; the requester's size for single dcache accesses.
- `arlen`/`awlen`: `LINE_WORDS`-1 if burst, else 0.
- Read FSM states and transitions:
  - R_IDLE → R_ADDR on grant. Grant requires a requester active and no RAW hazard.
  - R_ADDR → R_DATA when `arvalid`&&`arready`.
  - R_DATA → R_IDLE on `rvalid`&&`rlast`.
- Read arbitration: round-robin between icache and dcache. The last-granted pointer flips on each grant.
- RAW hazard: a dcache read is not granted while the write FSM is not idle and `dc_rd_addr[31:5]` equals the latched write address `[31:5]`. The icache is unaffected.
- In R_DATA:
  - `rready` = 1.
  - Beats are forwarded combinationally to the owner selected by `rid`: `*_rd_valid` = `rvalid` && owner match, `*_rd_last` = `rlast`.
  - Requesters must accept every beat.
- Write FSM states and transitions:
  - W_IDLE → W_ADDR on `dc_wr_req`, latching address, burst and size.
  - W_ADDR → W_DATA on `awready`.
  - W_DATA → W_RESP when the last beat handshakes.
  - W_RESP → W_IDLE on `bvalid`.
- In W_DATA:
  - `wvalid` = `dc_wd_valid` and `dc_wd_ready` = `wready`.
  - A beat counter clears on entry; `wlast` = (counter == `awlen`).
- `bready` = 1 only in W_RESP. `bresp` is ignored; `rresp` is ignored.
- Reset values, asserted asynchronously on `aresetn` low:
  - `arvalid`, `awvalid`, `rready`, `bready`, `wvalid` = 0.
  - All grants, valids and `dc_wr_done` = 0.
  - FSMs in IDLE; round-robin pointer = icache.
  - Mid-burst reset aborts the transaction; the AXI slave is reset by the same signal.

## Timing

- Grant pulse in the cycle the request is sampled in IDLE. `arvalid`/`awvalid` are registered and rise the following cycle.
- Address and length stay stable while `*valid`=1 and `*ready`=0.
- Read data latency is zero: a beat reaches the requester in the same cycle as `rvalid`.
- Minimum read turnaround: last beat, then 1 idle cycle, then next grant.
- `dc_wr_done` fires in the cycle after the `bvalid` handshake.
- Simultaneous read and write grants in the same cycle are permitted.

## Configuration

- `BRIDGE_DCACHE_PRIO_EN` defined: the dcache read always wins a simultaneous request and the round-robin pointer is removed.
- Undefined: round-robin as described above.

## Structure

- Package `bridge_pkg`:
  - FSM state enums.
  - ID constants `ID_ICACHE`=0, `ID_DCACHE`=1.
  - `BURST_INCR`, `SIZE_WORD`.
- One sub-module, `bridge_rd_arb`: two-requester arbiter with hazard masking and the macro-selected policy.

## Test plan

1. Icache line refill at 0xBFC00000, slave `arready` delayed 3 cycles:
   - AR: `arlen`=7, `arid`=0, `araddr` held stable until handshake.
   - 8 beats delivered to the icache only, `ic_rd_last` on beat 8.
2. Icache and dcache request in the same cycle, twice in a row:
   - Round-robin grants ic, dc, ic, dc.
   - With `BRIDGE_DCACHE_PRIO_EN`: dc always first.
3. Dcache writeback of 8 words to 0x00001000 with `wready` toggling every other cycle:
   - 8 W beats, `wlast` only on beat 8.
   - `dc_wr_done` one cycle after `bvalid`.
4. Uncached store, size 0, strb 4'b0010, to 0xBFAF0001:
   - `awlen`=0, `awsize`=0, single beat with `wlast`=1.
5. Dcache read to 0x00001004 while a write to 0x00001000 is in W_DATA:
   - No grant until `dc_wr_done`; an icache read in the same window is still granted.
6. `aresetn` dropped during R_DATA beat 4:
   - All valids/readies go to 0 immediately; after release, a new request proceeds normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// bridge_pkg: state encodings and fixed AXI field values shared by axi_cache_bridge
// and its read arbiter.
package bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    localparam logic [3:0] ID_ICACHE  = 4'd0;
    localparam logic [3:0] ID_DCACHE  = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

endpackage

// File: rtl/bridge_rd_arb.sv
// bridge_rd_arb: icache/dcache read arbiter with RAW-hazard masking of the dcache.
// BRIDGE_DCACHE_PRIO_EN selects fixed dcache priority instead of round-robin.
module bridge_rd_arb
    import bridge_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic arb_en_i,
    input  logic ic_req_i,
    input  logic dc_req_i,
    input  logic dc_hazard_i,
    output logic ic_gnt_o,
    output logic dc_gnt_o
);

    logic dc_ok;
    assign dc_ok = dc_req_i && !dc_hazard_i;

`ifdef BRIDGE_DCACHE_PRIO_EN
    logic unused_clk;
    assign unused_clk = aclk ^ aresetn;

    always_comb begin
        dc_gnt_o = arb_en_i && dc_ok;
        ic_gnt_o = arb_en_i && ic_req_i && !dc_ok;
    end
`else
    // dc_prio_q = 0 means the icache wins the next simultaneous request
    logic dc_prio_q, dc_prio_d;

    always_comb begin
        ic_gnt_o = 1'b0;
        dc_gnt_o = 1'b0;
        if (arb_en_i) begin
            if (ic_req_i && dc_ok) begin
                ic_gnt_o = !dc_prio_q;
                dc_gnt_o = dc_prio_q;
            end else begin
                ic_gnt_o = ic_req_i;
                dc_gnt_o = dc_ok;
            end
        end
        dc_prio_d = dc_prio_q ^ (ic_gnt_o | dc_gnt_o);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dc_prio_q <= 1'b0;
        end else begin
            dc_prio_q <= dc_prio_d;
        end
    end
`endif

endmodule

// File: rtl/axi_cache_bridge.sv
// axi_cache_bridge: turns Uranus icache/dcache line and single-word requests into AXI3
// bursts. Define BRIDGE_DCACHE_PRIO_EN for fixed dcache read priority.
module axi_cache_bridge
    import bridge_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ic_rd_req,
    input  logic        ic_rd_burst,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_gnt,
    output logic        ic_rd_valid,
    output logic        ic_rd_last,
    output logic [31:0] ic_rd_data,
    input  logic        dc_rd_req,
    input  logic        dc_rd_burst,
    input  logic [2:0]  dc_rd_size,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_gnt,
    output logic        dc_rd_valid,
    output logic        dc_rd_last,
    output logic [31:0] dc_rd_data,
    input  logic        dc_wr_req,
    input  logic        dc_wr_burst,
    input  logic [2:0]  dc_wr_size,
    input  logic [31:0] dc_wr_addr,
    output logic        dc_wr_gnt,
    input  logic        dc_wd_valid,
    input  logic [31:0] dc_wd_data,
    input  logic [3:0]  dc_wd_strb,
    output logic        dc_wd_ready,
    output logic        dc_wr_done,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [7:0]  ar_len_q, ar_len_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [3:0]  ar_id_q, ar_id_d;

    wr_state_e   wr_state_q, wr_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [7:0]  aw_len_q, aw_len_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic        wr_done_q, wr_done_d;

    logic ic_gnt, dc_gnt, rd_hazard, rd_beat, w_last_beat;

    logic unused_ok;
    assign unused_ok = ^{rresp, bid, bresp};

    // A dcache read of the line being written back must wait for the write to land
    assign rd_hazard = (wr_state_q != W_IDLE) && (dc_rd_addr[31:5] == aw_addr_q[31:5]);

    bridge_rd_arb u_rd_arb (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .arb_en_i    (aresetn && (rd_state_q == R_IDLE)),
        .ic_req_i    (ic_rd_req),
        .dc_req_i    (dc_rd_req),
        .dc_hazard_i (rd_hazard),
        .ic_gnt_o    (ic_gnt),
        .dc_gnt_o    (dc_gnt)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_id_d    = ar_id_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ic_gnt) begin
                    rd_state_d = R_ADDR;
                    ar_addr_d  = ic_rd_addr;
                    ar_len_d   = ic_rd_burst ? BURST_LEN : 8'd0;
                    ar_size_d  = SIZE_WORD;
                    ar_id_d    = ID_ICACHE;
                end else if (dc_gnt) begin
                    rd_state_d = R_ADDR;
                    ar_addr_d  = dc_rd_addr;
                    ar_len_d   = dc_rd_burst ? BURST_LEN : 8'd0;
                    ar_size_d  = dc_rd_burst ? SIZE_WORD : dc_rd_size;
                    ar_id_d    = ID_DCACHE;
                end
            end
            R_ADDR:  if (arready) rd_state_d = R_DATA;
            R_DATA:  if (rvalid && rlast) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign w_last_beat = (w_cnt_q == aw_len_q);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        w_cnt_d    = w_cnt_q;
        wr_done_d  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (dc_wr_gnt) begin
                    wr_state_d = W_ADDR;
                    aw_addr_d  = dc_wr_addr;
                    aw_len_d   = dc_wr_burst ? BURST_LEN : 8'd0;
                    aw_size_d  = dc_wr_burst ? SIZE_WORD : dc_wr_size;
                end
            end
            W_ADDR: begin
                if (awready) begin
                    wr_state_d = W_DATA;
                    w_cnt_d    = 8'd0;
                end
            end
            W_DATA: begin
                if (dc_wd_valid && wready) begin
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_last_beat) wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    wr_state_d = W_IDLE;
                    wr_done_d  = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_id_q    <= '0;
            wr_state_q <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            w_cnt_q    <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_id_q    <= ar_id_d;
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            w_cnt_q    <= w_cnt_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign ic_rd_gnt = ic_gnt;
    assign dc_rd_gnt = dc_gnt;
    assign dc_wr_gnt = aresetn && (wr_state_q == W_IDLE) && dc_wr_req;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (rd_state_q == R_ADDR);
    assign rready  = (rd_state_q == R_DATA);

    // Read beats bypass any buffering and go straight to the owner named by rid
    assign rd_beat     = (rd_state_q == R_DATA) && rvalid;
    assign ic_rd_valid = rd_beat && (rid == ID_ICACHE);
    assign dc_rd_valid = rd_beat && (rid == ID_DCACHE);
    assign ic_rd_last  = ic_rd_valid && rlast;
    assign dc_rd_last  = dc_rd_valid && rlast;
    assign ic_rd_data  = rdata;
    assign dc_rd_data  = rdata;

    assign awid    = ID_DCACHE;
    assign awaddr  = aw_addr_q;
    assign awlen   = aw_len_q;
    assign awsize  = aw_size_q;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (wr_state_q == W_ADDR);

    assign wid         = ID_DCACHE;
    assign wdata       = dc_wd_data;
    assign wstrb       = dc_wd_strb;
    assign wvalid      = (wr_state_q == W_DATA) && dc_wd_valid;
    assign wlast       = (wr_state_q == W_DATA) && w_last_beat;
    assign dc_wd_ready = (wr_state_q == W_DATA) && wready;
    assign bready      = (wr_state_q == W_RESP);
    assign dc_wr_done  = wr_done_q;

endmodule

// File: tb/tb_axi_cache_bridge.sv
// tb_axi_cache_bridge: directed scenarios for axi_cache_bridge with the bench acting as
// both cache requesters and the AXI slave; inputs change and outputs are sampled on negedge.
module tb_axi_cache_bridge;
    import bridge_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ic_rd_req, ic_rd_burst, ic_rd_gnt, ic_rd_valid, ic_rd_last;
    logic [31:0] ic_rd_addr, ic_rd_data;
    logic        dc_rd_req, dc_rd_burst, dc_rd_gnt, dc_rd_valid, dc_rd_last;
    logic [2:0]  dc_rd_size;
    logic [31:0] dc_rd_addr, dc_rd_data;
    logic        dc_wr_req, dc_wr_burst, dc_wr_gnt, dc_wd_valid, dc_wd_ready, dc_wr_done;
    logic [2:0]  dc_wr_size;
    logic [31:0] dc_wr_addr, dc_wd_data;
    logic [3:0]  dc_wd_strb;
    logic [3:0]  arid, arcache, rid, awid, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_cache_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_burst(ic_rd_burst), .ic_rd_addr(ic_rd_addr),
        .ic_rd_gnt(ic_rd_gnt), .ic_rd_valid(ic_rd_valid), .ic_rd_last(ic_rd_last),
        .ic_rd_data(ic_rd_data),
        .dc_rd_req(dc_rd_req), .dc_rd_burst(dc_rd_burst), .dc_rd_size(dc_rd_size),
        .dc_rd_addr(dc_rd_addr), .dc_rd_gnt(dc_rd_gnt), .dc_rd_valid(dc_rd_valid),
        .dc_rd_last(dc_rd_last), .dc_rd_data(dc_rd_data),
        .dc_wr_req(dc_wr_req), .dc_wr_burst(dc_wr_burst), .dc_wr_size(dc_wr_size),
        .dc_wr_addr(dc_wr_addr), .dc_wr_gnt(dc_wr_gnt),
        .dc_wd_valid(dc_wd_valid), .dc_wd_data(dc_wd_data), .dc_wd_strb(dc_wd_strb),
        .dc_wd_ready(dc_wd_ready), .dc_wr_done(dc_wr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic idle_inputs();
        ic_rd_req = 0; ic_rd_burst = 0; ic_rd_addr = '0;
        dc_rd_req = 0; dc_rd_burst = 0; dc_rd_size = 3'd2; dc_rd_addr = '0;
        dc_wr_req = 0; dc_wr_burst = 0; dc_wr_size = 3'd2; dc_wr_addr = '0;
        dc_wd_valid = 0; dc_wd_data = '0; dc_wd_strb = '0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        idle_inputs();
        aresetn = 0;
        @(negedge aclk);
        aresetn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 0;
        ic_rd_req = 1; dc_rd_req = 1; dc_wr_req = 1;
        repeat (2) @(negedge aclk);
        #1;
        checks++;
        if ({ic_rd_gnt, dc_rd_gnt, dc_wr_gnt} !== 3'b000) begin
            failures++; $display("FAIL reset_grants got=%b exp=000", {ic_rd_gnt, dc_rd_gnt, dc_wr_gnt});
        end
        checks++;
        if ({arvalid, awvalid, rready, bready, wvalid} !== 5'b0) begin
            failures++; $display("FAIL reset_axi got=%b exp=00000", {arvalid, awvalid, rready, bready, wvalid});
        end
        checks++;
        if ({ic_rd_valid, dc_rd_valid, dc_wd_ready, dc_wr_done} !== 4'b0) begin
            failures++; $display("FAIL reset_cache got=%b exp=0000", {ic_rd_valid, dc_rd_valid, dc_wd_ready, dc_wr_done});
        end
        @(negedge aclk);
        idle_inputs();
        aresetn = 1;
        $display("test_reset done");
    endtask

    task automatic test_icache_refill();
        logic [31:0] exp_data;
        @(negedge aclk);
        ic_rd_req = 1; ic_rd_burst = 1; ic_rd_addr = 32'hBFC0_0000;
        #1;
        checks++;
        if ({ic_rd_gnt, dc_rd_gnt, arvalid} !== 3'b100) begin
            failures++; $display("FAIL t1_grant got=%b exp=100", {ic_rd_gnt, dc_rd_gnt, arvalid});
        end
        @(negedge aclk);
        ic_rd_req = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge aclk);
            arready = (k == 3);
            #1;
            checks++;
            if ({arvalid, araddr, arlen, arid, arsize, arburst} !== {1'b1, 32'hBFC0_0000, 8'd7, 4'd0, 3'd2, 2'b01}) begin
                failures++; $display("FAIL t1_ar_stable cyc=%0d got=%b/%h/%0d/%0d/%0d exp=1/bfc00000/7/0/2", k, arvalid, araddr, arlen, arid, arsize);
            end
        end
        @(negedge aclk);
        arready = 0;
        for (int i = 0; i < 8; i++) begin
            exp_data = 32'hA5A5_0000 + i;
            rvalid = 1; rid = 4'd0; rlast = (i == 7); rdata = exp_data;
            #1;
            checks++;
            if ({rready, ic_rd_valid, dc_rd_valid, ic_rd_last, ic_rd_data} !== {1'b1, 1'b1, 1'b0, (i == 7), exp_data}) begin
                failures++; $display("FAIL t1_beat%0d got=rr%b iv%b dv%b il%b d=%h exp=rr1 iv1 dv0 il%b d=%h", i, rready, ic_rd_valid, dc_rd_valid, ic_rd_last, ic_rd_data, (i == 7), exp_data);
            end
            @(negedge aclk);
        end
        rvalid = 0; rlast = 0;
        #1;
        checks++;
        if ({rready, arvalid, ic_rd_valid} !== 3'b000) begin
            failures++; $display("FAIL t1_after got=%b exp=000", {rready, arvalid, ic_rd_valid});
        end
        $display("test_icache_refill done");
    endtask

    task automatic test_round_robin();
        logic exp_dc [4];
        logic [3:0] exp_id;
`ifdef BRIDGE_DCACHE_PRIO_EN
        exp_dc = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_dc = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        @(negedge aclk);
        for (int g = 0; g < 4; g++) begin
            exp_id = exp_dc[g] ? ID_DCACHE : ID_ICACHE;
            if (g % 2 == 0) begin
                ic_rd_req = 1; dc_rd_req = 1;
            end
            ic_rd_burst = 0; ic_rd_addr = 32'h1FC0_0000 + g * 4;
            dc_rd_burst = 0; dc_rd_size = 3'd2; dc_rd_addr = 32'h0000_2000 + g * 4;
            #1;
            checks++;
            if ({ic_rd_gnt, dc_rd_gnt} !== (exp_dc[g] ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL rr_grant%0d got=ic%b dc%b exp_dc=%b", g, ic_rd_gnt, dc_rd_gnt, exp_dc[g]);
            end
            @(negedge aclk);
            if (exp_dc[g]) dc_rd_req = 0; else ic_rd_req = 0;
            arready = 1;
            #1;
            checks++;
            if ({arvalid, arid, arlen} !== {1'b1, exp_id, 8'd0}) begin
                failures++; $display("FAIL rr_ar%0d got=%b/%0d/%0d exp=1/%0d/0", g, arvalid, arid, arlen, exp_id);
            end
            @(negedge aclk);
            arready = 0; rvalid = 1; rlast = 1; rid = exp_id; rdata = 32'h0000_0100 + g;
            #1;
            checks++;
            if ({ic_rd_valid, dc_rd_valid} !== (exp_dc[g] ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL rr_owner%0d got=ic%b dc%b exp_dc=%b", g, ic_rd_valid, dc_rd_valid, exp_dc[g]);
            end
            @(negedge aclk);
            rvalid = 0; rlast = 0;
        end
        idle_inputs();
        $display("test_round_robin done");
    endtask

    task automatic test_writeback();
        int beat;
        logic [31:0] exp_data;
        @(negedge aclk);
        dc_wr_req = 1; dc_wr_burst = 1; dc_wr_size = 3'd2; dc_wr_addr = 32'h0000_1000;
        #1;
        checks++;
        if ({dc_wr_gnt, awvalid} !== 2'b10) begin
            failures++; $display("FAIL t3_grant got=%b exp=10", {dc_wr_gnt, awvalid});
        end
        @(negedge aclk);
        dc_wr_req = 0; awready = 1;
        #1;
        checks++;
        if ({awvalid, awaddr, awlen, awsize, awid, awburst} !== {1'b1, 32'h0000_1000, 8'd7, 3'd2, 4'd1, 2'b01}) begin
            failures++; $display("FAIL t3_aw got=%b/%h/%0d/%0d/%0d/%b exp=1/00001000/7/2/1/01", awvalid, awaddr, awlen, awsize, awid, awburst);
        end
        @(negedge aclk);
        awready = 0;
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            if (c > 0) @(negedge aclk);
            exp_data = 32'hD000_0000 + beat;
            dc_wd_valid = 1; dc_wd_data = exp_data; dc_wd_strb = 4'hF; wready = (c % 2 == 1);
            #1;
            checks++;
            if ({wvalid, dc_wd_ready, wlast, wdata, wid} !== {1'b1, wready, (beat == 7), exp_data, 4'd1}) begin
                failures++; $display("FAIL t3_w cyc=%0d beat=%0d got=v%b r%b l%b d=%h exp=v1 r%b l%b d=%h", c, beat, wvalid, dc_wd_ready, wlast, wdata, wready, (beat == 7), exp_data);
            end
            if (wready) beat++;
        end
        @(negedge aclk);
        dc_wd_valid = 0; wready = 0;
        #1;
        checks++;
        if ({bready, wvalid, dc_wr_done} !== 3'b100) begin
            failures++; $display("FAIL t3_resp_wait got=%b exp=100", {bready, wvalid, dc_wr_done});
        end
        @(negedge aclk);
        bvalid = 1;
        #1;
        checks++;
        if ({bready, dc_wr_done} !== 2'b10) begin
            failures++; $display("FAIL t3_bvalid got=%b exp=10", {bready, dc_wr_done});
        end
        @(negedge aclk);
        bvalid = 0;
        #1;
        checks++;
        if ({dc_wr_done, bready} !== 2'b10) begin
            failures++; $display("FAIL t3_done got=%b exp=10", {dc_wr_done, bready});
        end
        @(negedge aclk);
        #1;
        checks++;
        if (dc_wr_done !== 1'b0) begin
            failures++; $display("FAIL t3_done_pulse got=%b exp=0", dc_wr_done);
        end
        $display("test_writeback done");
    endtask

    task automatic test_uncached_store();
        @(negedge aclk);
        dc_wr_req = 1; dc_wr_burst = 0; dc_wr_size = 3'd0; dc_wr_addr = 32'hBFAF_0001;
        #1;
        checks++;
        if (dc_wr_gnt !== 1'b1) begin
            failures++; $display("FAIL t4_grant got=%b exp=1", dc_wr_gnt);
        end
        @(negedge aclk);
        dc_wr_req = 0; awready = 1;
        #1;
        checks++;
        if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'hBFAF_0001, 8'd0, 3'd0}) begin
            failures++; $display("FAIL t4_aw got=%b/%h/%0d/%0d exp=1/bfaf0001/0/0", awvalid, awaddr, awlen, awsize);
        end
        @(negedge aclk);
        awready = 0; dc_wd_valid = 1; dc_wd_data = 32'h0000_AB00; dc_wd_strb = 4'b0010; wready = 1;
        #1;
        checks++;
        if ({wvalid, wlast, wstrb, wdata, dc_wd_ready} !== {1'b1, 1'b1, 4'b0010, 32'h0000_AB00, 1'b1}) begin
            failures++; $display("FAIL t4_w got=v%b l%b s%b d=%h r%b exp=v1 l1 s0010 d=0000ab00 r1", wvalid, wlast, wstrb, wdata, dc_wd_ready);
        end
        @(negedge aclk);
        dc_wd_valid = 0; wready = 0; bvalid = 1;
        #1;
        checks++;
        if ({bready, wvalid} !== 2'b10) begin
            failures++; $display("FAIL t4_bready got=%b exp=10", {bready, wvalid});
        end
        @(negedge aclk);
        bvalid = 0;
        #1;
        checks++;
        if (dc_wr_done !== 1'b1) begin
            failures++; $display("FAIL t4_done got=%b exp=1", dc_wr_done);
        end
        idle_inputs();
        $display("test_uncached_store done");
    endtask

    task automatic test_raw_hazard();
        @(negedge aclk);
        dc_wr_req = 1; dc_wr_burst = 1; dc_wr_size = 3'd2; dc_wr_addr = 32'h0000_1000;
        @(negedge aclk);
        dc_wr_req = 0; awready = 1;
        @(negedge aclk);
        awready = 0;
        dc_rd_req = 1; dc_rd_burst = 0; dc_rd_size = 3'd2; dc_rd_addr = 32'h0000_1004;
        ic_rd_req = 1; ic_rd_burst = 0; ic_rd_addr = 32'hBFC0_0100;
        #1;
        checks++;
        if ({ic_rd_gnt, dc_rd_gnt} !== 2'b10) begin
            failures++; $display("FAIL t5_masked got=ic%b dc%b exp=ic1 dc0", ic_rd_gnt, dc_rd_gnt);
        end
        @(negedge aclk);
        ic_rd_req = 0; arready = 1;
        #1;
        checks++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'hBFC0_0100}) begin
            failures++; $display("FAIL t5_ic_ar got=%b/%0d/%h exp=1/0/bfc00100", arvalid, arid, araddr);
        end
        @(negedge aclk);
        arready = 0; rvalid = 1; rlast = 1; rid = 4'd0; rdata = 32'h1CE0_0001;
        #1;
        checks++;
        if ({ic_rd_valid, dc_rd_valid, ic_rd_data} !== {1'b1, 1'b0, 32'h1CE0_0001}) begin
            failures++; $display("FAIL t5_ic_beat got=iv%b dv%b d=%h exp=iv1 dv0 d=1ce00001", ic_rd_valid, dc_rd_valid, ic_rd_data);
        end
        @(negedge aclk);
        rvalid = 0; rlast = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge aclk);
            dc_wd_valid = 1; dc_wd_data = 32'hE000_0000 + i; dc_wd_strb = 4'hF; wready = 1;
            #1;
            checks++;
            if (dc_rd_gnt !== 1'b0) begin
                failures++; $display("FAIL t5_hold%0d got=%b exp=0", i, dc_rd_gnt);
            end
        end
        @(negedge aclk);
        dc_wd_valid = 0; wready = 0; bvalid = 1;
        #1;
        checks++;
        if ({dc_rd_gnt, bready} !== 2'b01) begin
            failures++; $display("FAIL t5_resp got=gnt%b bready%b exp=gnt0 bready1", dc_rd_gnt, bready);
        end
        @(negedge aclk);
        bvalid = 0;
        #1;
        checks++;
        if ({dc_wr_done, dc_rd_gnt} !== 2'b11) begin
            failures++; $display("FAIL t5_release got=done%b gnt%b exp=done1 gnt1", dc_wr_done, dc_rd_gnt);
        end
        @(negedge aclk);
        dc_rd_req = 0; arready = 1;
        #1;
        checks++;
        if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd1, 32'h0000_1004, 3'd2}) begin
            failures++; $display("FAIL t5_dc_ar got=%b/%0d/%h/%0d exp=1/1/00001004/2", arvalid, arid, araddr, arsize);
        end
        @(negedge aclk);
        arready = 0; rvalid = 1; rlast = 1; rid = 4'd1; rdata = 32'hDC00_1004;
        #1;
        checks++;
        if ({dc_rd_valid, ic_rd_valid, dc_rd_last, dc_rd_data} !== {1'b1, 1'b0, 1'b1, 32'hDC00_1004}) begin
            failures++; $display("FAIL t5_dc_beat got=dv%b iv%b dl%b d=%h exp=dv1 iv0 dl1 d=dc001004", dc_rd_valid, ic_rd_valid, dc_rd_last, dc_rd_data);
        end
        @(negedge aclk);
        idle_inputs();
        $display("test_raw_hazard done");
    endtask

    task automatic test_reset_mid_burst();
        @(negedge aclk);
        ic_rd_req = 1; ic_rd_burst = 1; ic_rd_addr = 32'hBFC0_0200;
        @(negedge aclk);
        ic_rd_req = 0; arready = 1;
        @(negedge aclk);
        arready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge aclk);
            rvalid = 1; rid = 4'd0; rlast = 0; rdata = 32'hC000_0000 + i;
        end
        #1;
        checks++;
        if (ic_rd_valid !== 1'b1) begin
            failures++; $display("FAIL t6_beat4 got=%b exp=1", ic_rd_valid);
        end
        #1 aresetn = 0;
        #1;
        checks++;
        if ({arvalid, awvalid, rready, bready, wvalid, ic_rd_valid, dc_rd_valid, dc_wr_done} !== 8'b0) begin
            failures++; $display("FAIL t6_async got=%b exp=00000000", {arvalid, awvalid, rready, bready, wvalid, ic_rd_valid, dc_rd_valid, dc_wr_done});
        end
        rvalid = 0;
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        dc_rd_req = 1; dc_rd_burst = 0; dc_rd_size = 3'd1; dc_rd_addr = 32'h0000_2002;
        #1;
        checks++;
        if ({dc_rd_gnt, ic_rd_gnt} !== 2'b10) begin
            failures++; $display("FAIL t6_regrant got=dc%b ic%b exp=dc1 ic0", dc_rd_gnt, ic_rd_gnt);
        end
        @(negedge aclk);
        dc_rd_req = 0; arready = 1;
        #1;
        checks++;
        if ({arvalid, araddr, arsize, arlen, arid} !== {1'b1, 32'h0000_2002, 3'd1, 8'd0, 4'd1}) begin
            failures++; $display("FAIL t6_ar got=%b/%h/%0d/%0d/%0d exp=1/00002002/1/0/1", arvalid, araddr, arsize, arlen, arid);
        end
        @(negedge aclk);
        arready = 0; rvalid = 1; rlast = 1; rid = 4'd1; rdata = 32'h0000_600D;
        #1;
        checks++;
        if ({dc_rd_valid, dc_rd_last, dc_rd_data, ic_rd_valid} !== {1'b1, 1'b1, 32'h0000_600D, 1'b0}) begin
            failures++; $display("FAIL t6_beat got=dv%b dl%b d=%h iv%b exp=dv1 dl1 d=0000600d iv0", dc_rd_valid, dc_rd_last, dc_rd_data, ic_rd_valid);
        end
        @(negedge aclk);
        idle_inputs();
        #1;
        checks++;
        if ({rready, arvalid} !== 2'b00) begin
            failures++; $display("FAIL t6_idle got=%b exp=00", {rready, arvalid});
        end
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        test_reset();
        test_icache_refill();
        test_round_robin();
        test_writeback();
        test_uncached_store();
        test_raw_hazard();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
